// File: rtl/clear_cond_code_pkg.sv
// Shared constants for the condition-code block: PSR bit positions,
// condition-code selectors and default datapath sizes.
package clear_cond_code_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SBITS = 5;

  // PSR bit positions
  localparam int unsigned CARRY  = 0;
  localparam int unsigned EVEN   = 1;
  localparam int unsigned PARITY = 2;
  localparam int unsigned ZERO   = 3;
  localparam int unsigned NEG    = 4;

  // Condition-code selectors
  localparam logic [3:0] CCA = 4'd0;
  localparam logic [3:0] CCC = 4'd1;
  localparam logic [3:0] CCE = 4'd2;
  localparam logic [3:0] CCP = 4'd3;
  localparam logic [3:0] CCZ = 4'd4;
  localparam logic [3:0] CCN = 4'd5;

endpackage

// File: rtl/clear_cond_code_cc_compute.sv
// Maps an ALU result (carry-out in the top bit) to the five PSR flag values.
module cc_compute
  import clear_cond_code_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0] res_i,
  output logic           carry_o,
  output logic           even_o,
  output logic           parity_o,
  output logic           zero_o,
  output logic           neg_o
);

  always_comb begin
    carry_o  = res_i[WIDTH];
    even_o   = ~res_i[0];
    parity_o = ^res_i;
    zero_o   = (res_i == '0);
    neg_o    = res_i[WIDTH-1];
  end

endmodule

// File: rtl/clear_cond_code.sv
// Processor status register with load/set/clear priority and a
// combinational condition-code test against the registered flags.
module clear_cond_code
  import clear_cond_code_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SBITS = DEF_SBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set,
  input  logic [WIDTH:0]   res,
  input  logic             load,
  input  logic [SBITS-1:0] psr_in,
  input  logic [3:0]       ccode,
  output logic [SBITS-1:0] psr,
  output logic             cond_true
);

  logic [SBITS-1:0] psr_q, psr_d, set_vals;
  logic carry, even, parity, zero, neg;

  cc_compute #(.WIDTH(WIDTH)) u_cc_compute (
    .res_i    (res),
    .carry_o  (carry),
    .even_o   (even),
    .parity_o (parity),
    .zero_o   (zero),
    .neg_o    (neg)
  );

  always_comb begin
    set_vals         = '0;
    set_vals[CARRY]  = carry;
    set_vals[EVEN]   = even;
    set_vals[PARITY] = parity;
    set_vals[ZERO]   = zero;
    set_vals[NEG]    = neg;
  end

  // set outranks clear, so clear+set behaves as clear-then-set
  always_comb begin
    psr_d = psr_q;
    if (load)       psr_d = psr_in;
    else if (set)   psr_d = set_vals;
    else if (clear) psr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) psr_q <= '0;
    else        psr_q <= psr_d;
  end

  assign psr = psr_q;

  always_comb begin
    cond_true = 1'b0;
    case (ccode)
      CCA:     cond_true = 1'b1;
      CCC:     cond_true = psr_q[CARRY];
      CCE:     cond_true = psr_q[EVEN];
      CCP:     cond_true = psr_q[PARITY];
      CCZ:     cond_true = psr_q[ZERO];
      CCN:     cond_true = psr_q[NEG];
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clear_cond_code.sv
// Self-checking bench: directed vector table, hand sequences for reset and
// hold corners, then random stimulus against a behavioural flag model.
module tb_clear_cond_code;

  logic        clk = 1'b0;
  logic        reset, clear, set, load;
  logic [32:0] res;
  logic [4:0]  psr_in;
  logic [3:0]  ccode;
  logic [4:0]  psr;
  logic        cond_true;

  int errors = 0;
  int checks = 0;

  clear_cond_code #(.WIDTH(32), .SBITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .set       (set),
    .res       (res),
    .load      (load),
    .psr_in    (psr_in),
    .ccode     (ccode),
    .psr       (psr),
    .cond_true (cond_true)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, clr, st, ld;
    logic [32:0] r;
    logic [4:0]  pin;
    logic [3:0]  cc;
    logic [4:0]  exp_psr;
    logic        exp_cond;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic clr, input logic st, input logic ld,
                       input logic [32:0] r, input logic [4:0] pin, input logic [3:0] cc);
    reset = rst_n; clear = clr; set = st; load = ld; res = r; psr_in = pin; ccode = cc;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: flags straight from their arithmetic definitions
  function automatic logic [4:0] model_set(input logic [32:0] r);
    logic [4:0] f;
    f[0] = r[32];
    f[1] = (r % 2 == 0);
    f[2] = ($countones(r) % 2 == 1);
    f[3] = (r == 33'd0);
    f[4] = r[31];
    return f;
  endfunction

  function automatic logic model_cond(input logic [4:0] p, input int cc);
    if (cc == 0) return 1'b1;
    if (cc >= 1 && cc <= 5) return p[cc-1];
    return 1'b0;
  endfunction

  logic [4:0] m;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 4'd0);

    vecs[0]  = '{1'b0,1'b0,1'b1,1'b1, 33'h1_0000_0000, 5'h1F, 4'd0, 5'b00000, 1'b1, "reset_cca"};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 33'h0,           5'h00, 4'd4, 5'b00000, 1'b0, "reset_ccz"};
    vecs[2]  = '{1'b1,1'b0,1'b1,1'b0, 33'h1_0000_0000, 5'h00, 4'd1, 5'b00111, 1'b1, "carry_ccc"};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 33'h0_1234_5678, 5'h00, 4'd4, 5'b00111, 1'b0, "carry_ccz"};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b0, 33'h0,           5'h00, 4'd4, 5'b01010, 1'b1, "zero_ccz"};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0, 33'h1_FFFF_FFFF, 5'h1F, 4'd3, 5'b01010, 1'b0, "zero_ccp"};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0, 33'h0_8000_0001, 5'h00, 4'd5, 5'b10000, 1'b1, "neg_ccn"};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 33'h0,           5'h00, 4'd2, 5'b10000, 1'b0, "neg_cce"};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b0, 33'h0,           5'h00, 4'd4, 5'b01010, 1'b1, "clrset"};
    vecs[9]  = '{1'b1,1'b1,1'b0,1'b0, 33'h1_0000_0000, 5'h00, 4'd2, 5'b00000, 1'b0, "clear"};
    vecs[10] = '{1'b1,1'b1,1'b1,1'b1, 33'h0_8000_0001, 5'h1F, 4'd0, 5'b11111, 1'b1, "load_prio"};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0, 33'h0,           5'h00, 4'd1, 5'b11111, 1'b1, "load_ccc"};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst_n, vecs[i].clr, vecs[i].st, vecs[i].ld, vecs[i].r, vecs[i].pin, vecs[i].cc);
      tick();
      check({vecs[i].name, "_psr"},  32'(psr),       32'(vecs[i].exp_psr));
      check({vecs[i].name, "_cond"}, 32'(cond_true), 32'(vecs[i].exp_cond));
    end

    // Undefined codes with all flags set; combinational only
    for (int c = 6; c < 16; c++) begin
      ccode = 4'(c);
      #1;
      check($sformatf("undef_cc%0d", c), 32'(cond_true), 32'd0);
    end

    // Idle hold for 10 cycles with noisy don't-care inputs
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 33'({$urandom, $urandom}), 5'($urandom), 4'd0);
      tick();
      check($sformatf("hold_%0d", k), 32'(psr), 32'h1F);
    end

    // Same-cycle res change must not bypass into cond_true
    drive(1'b1, 1'b0, 1'b0, 1'b0, 33'h0, 5'h0, 4'd4);
    #1;
    check("no_bypass", 32'(cond_true), 32'd1);

    // Reset wins over load, then release followed by normal set
    drive(1'b0, 1'b0, 1'b0, 1'b1, 33'h0, 5'h1F, 4'd0);
    tick();
    check("rst_over_load", 32'(psr), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 33'h1_0000_0000, 5'h00, 4'd1);
    tick();
    check("post_rst_set", 32'(psr), 32'b00111);
    check("post_rst_cond", 32'(cond_true), 32'd1);

    // Randomized run against the model
    m = psr;
    for (int n = 0; n < 400; n++) begin
      logic        rr, cl, st, ld;
      logic [32:0] r;
      logic [4:0]  pin;
      logic [3:0]  cc;
      rr  = ($urandom % 20) != 0;
      cl  = ($urandom % 3) == 0;
      st  = ($urandom % 2) == 0;
      ld  = ($urandom % 8) == 0;
      r   = 33'({$urandom_range(1, 0), $urandom});
      if ($urandom % 8 == 0) r = '0;
      pin = 5'($urandom);
      cc  = 4'($urandom);
      drive(rr, cl, st, ld, r, pin, cc);
      if (!rr)     m = 5'd0;
      else if (ld) m = pin;
      else if (st) m = model_set(r);
      else if (cl) m = 5'd0;
      tick();
      check($sformatf("rand%0d_psr", n),  32'(psr),       32'(m));
      check($sformatf("rand%0d_cond", n), 32'(cond_true), 32'(model_cond(m, int'(cc))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clear_cond_code.md
CLEAR_COND_CODE -- requirements
Module: clear_cond_code

Interface
REQ-001 Parameter WIDTH, default 32: ALU datapath width; the result input is WIDTH+1 bits wide.
REQ-002 Parameter SBITS, default 5: processor status register (PSR) width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 clear  input  1  clears all condition codes this cycle.
REQ-006 set  input  1  updates condition codes from res this cycle.
REQ-007 res  input  WIDTH+1  ALU result; bit WIDTH is carry-out.
REQ-008 load  input  1  loads psr_in directly into the PSR (context restore).
REQ-009 psr_in  input  SBITS  value written by load.
REQ-010 ccode  input  4  condition code to test.
REQ-011 psr  output  SBITS  registered PSR: bit0 CARRY, bit1 EVEN, bit2 PARITY, bit3 ZERO, bit4 NEG.
REQ-012 cond_true  output  1  combinational result of testing ccode against psr.

Function
REQ-013 Set values: CARRY=res[WIDTH]; EVEN=~res[0]; PARITY=XOR-reduce of all WIDTH+1 bits of res; ZERO=1 iff all WIDTH+1 bits of res are 0; NEG=res[WIDTH-1].
REQ-014 Per-edge priority: reset asserted -> psr=0; else load -> psr=psr_in; else set -> psr=set values (REQ-013); else clear -> psr=0; else psr holds.
REQ-015 When clear and set are both asserted in one cycle, the PSR takes the set values; this is the clear-then-set sequence.
REQ-016 Any update takes effect at the next rising edge, so psr latency is 1 cycle.
REQ-017 cond_true by ccode: 0 CCA always 1; 1 CARRY; 2 EVEN; 3 PARITY; 4 ZERO; 5 NEG; 6..15 give 0.
REQ-018 cond_true depends only on ccode and the registered psr, with no bypass from res in the same cycle.
REQ-019 No handshake: every input is sampled on every edge, and inputs are don't-care when their enable is low.
REQ-020 With all enables low, psr holds its value indefinitely.

Reset
REQ-021 While reset=0 at a rising edge, psr becomes 0 regardless of load, set or clear.
REQ-022 After reset, cond_true=1 only for ccode=0.
REQ-023 Deasserting reset mid-operation has no side effects: the next edge follows REQ-014.

Structure
REQ-024 A shared package holds:
- PSR bit index constants CARRY=0, EVEN=1, PARITY=2, ZERO=3, NEG=4.
- Condition code constants CCA=0, CCC=1, CCE=2, CCP=3, CCZ=4, CCN=5.
- Default WIDTH and SBITS.
REQ-025 A single combinational sub-module, cc_compute, maps res to the five set values.
REQ-026 The PSR register and the ccode decode live in the top module.

Verification
REQ-027 Reset: reset=0 for one edge, then ccode=0 and ccode=4 -> psr=5'b00000, cond_true 1 then 0.
REQ-028 Carry: set with res=33'h1_0000_0000 -> psr=5'b00111; ccode=1 gives cond_true=1; ccode=4 gives 0.
REQ-029 Zero: set with res=33'h0_0000_0000 -> psr=5'b01010; ccode=4 gives 1; ccode=3 gives 0.
REQ-030 Negative: set with res=33'h0_8000_0001 -> psr=5'b10000; ccode=5 gives 1; ccode=2 gives 0.
REQ-031 Priority:
- clear+set with res=0 -> psr=5'b01010.
- Then clear alone -> 5'b00000.
- load with psr_in=5'b11111 while set and clear are high -> 5'b11111.
REQ-032 Undefined and hold: ccode=6..15 with psr=5'b11111 -> cond_true=0; 10 idle cycles -> psr unchanged.
